// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_timing_pkg : 640x480 timing constants and receiver state encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int c_H_ACTIVE = 640;
    localparam int c_V_ACTIVE = 480;
    localparam int c_H_TOTAL  = 800;
    localparam int c_V_TOTAL  = 525;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_edge_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_edge_detect : input register with rise/fall pulses against its history
// Revision: 1.0
// ---------------------------------------------------------------------------
module vga_edge_detect (
    input  logic iCLK,
    input  logic iRST_n,
    input  logic iD,
    output logic oQ,
    output logic oRise,
    output logic oFall
);

    logic r_q;
    logic r_qPrev;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_q     <= 1'b0;
            r_qPrev <= 1'b0;
        end else begin
            r_q     <= iD;
            r_qPrev <= r_q;
        end
    end

    assign oQ    = r_q;
    assign oRise = r_q & ~r_qPrev;
    assign oFall = ~r_q & r_qPrev;

endmodule
`default_nettype wire

// File: rtl/vga_sync_receiver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_sync_receiver : recovers pixel position, measures geometry, locks, probes
// Revision: 1.0
// ---------------------------------------------------------------------------
module vga_sync_receiver
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = c_H_ACTIVE,
    parameter int V_ACTIVE    = c_V_ACTIVE,
    parameter int H_TOTAL     = c_H_TOTAL,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        iHS,
    input  logic        iVS,
    input  logic        iBLANK_n,
    input  logic [3:0]  iVGA_R,
    input  logic [3:0]  iVGA_G,
    input  logic [3:0]  iVGA_B,
    input  logic [10:0] iPROBE_X,
    input  logic [9:0]  iPROBE_Y,
    output logic [10:0] oXPOS,
    output logic [9:0]  oYPOS,
    output logic        oPIX_VALID,
    output logic        oLOCKED,
    output logic [10:0] oLINE_LEN,
    output logic [9:0]  oFRAME_LINES,
    output logic [11:0] oPROBE_RGB,
    output logic        oPROBE_STB,
    output logic        oERR
);

    localparam logic [10:0] c_X_MAX  = 11'h7FF;
    localparam logic [9:0]  c_Y_MAX  = 10'h3FF;
    localparam logic [11:0] c_HS_MAX = 12'hFFF;

    logic w_hsQ, w_hsRise, w_hsFall;
    logic w_vsQ, w_vsRise, w_vsFall;
    logic w_blank, w_blankRise, w_blankFall;
    logic w_unused;

    vga_edge_detect u_hsEdge (
        .iCLK(iVGA_CLK), .iRST_n(iRST_n), .iD(iHS),
        .oQ(w_hsQ), .oRise(w_hsRise), .oFall(w_hsFall)
    );
    vga_edge_detect u_vsEdge (
        .iCLK(iVGA_CLK), .iRST_n(iRST_n), .iD(iVS),
        .oQ(w_vsQ), .oRise(w_vsRise), .oFall(w_vsFall)
    );
    vga_edge_detect u_blankEdge (
        .iCLK(iVGA_CLK), .iRST_n(iRST_n), .iD(iBLANK_n),
        .oQ(w_blank), .oRise(w_blankRise), .oFall(w_blankFall)
    );

    assign w_unused = w_hsQ ^ w_hsRise ^ w_vsQ ^ w_vsRise;

    logic [11:0] r_rgb;
    logic [10:0] r_probeX;
    logic [9:0]  r_probeY;
    logic [10:0] r_x;
    logic [9:0]  r_y;
    logic        r_pixValid;
    logic [11:0] r_hsCnt;
    logic        r_hsArmed;
    logic [10:0] r_lastLineLen;
    logic        r_lineErr;
    logic        r_frameBad;
    logic        r_err;
    logic [10:0] r_lineLen;
    logic [9:0]  r_frameLines;
    logic [11:0] r_probeRgb;
    logic        r_probeStb;
    logic [3:0]  r_goodCnt;
    rx_state_t   r_state;

    logic [11:0] w_xInc;
    logic [10:0] w_xNext;
    logic [10:0] w_lineLenNow;
    logic        w_xOver;
    logic        w_lineBad;
    logic [12:0] w_hsPeriod;
    logic        w_hsBad;
    logic        w_frameGood;
    logic [4:0]  w_goodInc;
    logic        w_probeHit;
    rx_state_t   w_stateNext;
    logic [3:0]  w_goodNext;
    logic        w_enterAcq;
    logic        w_errSet;

    // x+1 is one bit wider so a saturated 2047-wide line still compares correctly
    assign w_xInc       = {1'b0, r_x} + 12'd1;
    assign w_lineLenNow = (r_x == c_X_MAX) ? c_X_MAX : w_xInc[10:0];

    always_comb begin
        w_xNext = r_x;
        if (w_blankRise)
            w_xNext = '0;
        else if (w_blank && (r_x != c_X_MAX))
            w_xNext = w_xInc[10:0];
    end

    assign w_xOver     = w_blank && !w_blankRise && (w_xNext >= 11'(H_ACTIVE));
    assign w_lineBad   = w_blankFall && (w_xInc != 12'(H_ACTIVE));
    assign w_hsPeriod  = {1'b0, r_hsCnt} + 13'd1;
    assign w_hsBad     = w_hsFall && r_hsArmed && (w_hsPeriod != 13'(H_TOTAL));
    assign w_frameGood = !(r_frameBad || r_lineErr || w_lineBad || w_hsBad || w_xOver)
                         && (r_y == 10'(V_ACTIVE));
    assign w_goodInc   = {1'b0, r_goodCnt} + 5'd1;
    assign w_probeHit  = (r_state == LOCKED) && w_blank
                         && (w_xNext == r_probeX) && (r_y == r_probeY)
                         && (r_probeX < 11'(H_ACTIVE)) && (r_probeY < 10'(V_ACTIVE));

    always_comb begin
        w_stateNext = r_state;
        w_goodNext  = r_goodCnt;
        w_enterAcq  = 1'b0;
        w_errSet    = 1'b0;
        if (w_vsFall) begin
            case (r_state)
                SEARCH: begin
                    w_stateNext = ACQUIRE;
                    w_goodNext  = '0;
                    w_enterAcq  = 1'b1;
                end
                ACQUIRE: begin
                    if (!w_frameGood) begin
                        w_goodNext = '0;
                    end else if (w_goodInc >= 5'(LOCK_FRAMES)) begin
                        w_stateNext = LOCKED;
                        w_goodNext  = '0;
                    end else begin
                        w_goodNext = w_goodInc[3:0];
                    end
                end
                LOCKED: begin
                    if (!w_frameGood) begin
                        w_stateNext = ACQUIRE;
                        w_goodNext  = '0;
                        w_enterAcq  = 1'b1;
                        w_errSet    = 1'b1;
                    end
                end
                default: w_stateNext = SEARCH;
            endcase
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state   <= SEARCH;
            r_goodCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_goodCnt <= w_goodNext;
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_rgb         <= '0;
            r_probeX      <= '0;
            r_probeY      <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_pixValid    <= 1'b0;
            r_hsCnt       <= '0;
            r_hsArmed     <= 1'b0;
            r_lastLineLen <= '0;
            r_lineErr     <= 1'b0;
            r_frameBad    <= 1'b0;
            r_err         <= 1'b0;
            r_lineLen     <= '0;
            r_frameLines  <= '0;
            r_probeRgb    <= '0;
            r_probeStb    <= 1'b0;
        end else begin
            r_rgb      <= {iVGA_R, iVGA_G, iVGA_B};
            r_probeX   <= iPROBE_X;
            r_probeY   <= iPROBE_Y;
            r_x        <= w_xNext;
            r_pixValid <= w_blank;

            if (w_vsFall)
                r_y <= '0;
            else if (w_blankFall && (r_y != c_Y_MAX))
                r_y <= r_y + 10'd1;

            if (w_hsFall)
                r_hsCnt <= '0;
            else if (r_hsCnt != c_HS_MAX)
                r_hsCnt <= r_hsCnt + 12'd1;

            // The first HS period after (re)entering ACQUIRE may straddle a discontinuity
            if (w_enterAcq)
                r_hsArmed <= 1'b0;
            else if (w_hsFall)
                r_hsArmed <= 1'b1;

            if (w_blankFall)
                r_lastLineLen <= w_lineLenNow;

            if (w_vsFall) begin
                r_lineErr    <= 1'b0;
                r_frameBad   <= 1'b0;
                r_frameLines <= r_y;
                r_lineLen    <= w_blankFall ? w_lineLenNow : r_lastLineLen;
            end else begin
                if (w_xOver)
                    r_lineErr <= 1'b1;
                if (w_lineBad || w_hsBad)
                    r_frameBad <= 1'b1;
            end

            if (w_errSet)
                r_err <= 1'b1;

            r_probeStb <= w_probeHit;
            if (w_probeHit)
                r_probeRgb <= r_rgb;
        end
    end

    assign oXPOS        = r_x;
    assign oYPOS        = r_y;
    assign oPIX_VALID   = r_pixValid;
    assign oLOCKED      = (r_state == LOCKED);
    assign oLINE_LEN    = r_lineLen;
    assign oFRAME_LINES = r_frameLines;
    assign oPROBE_RGB   = r_probeRgb;
    assign oPROBE_STB   = r_probeStb;
    assign oERR         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_receiver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vga_sync_receiver : frame-table stimulus with a pixel-position scoreboard
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_vga_sync_receiver;

    // Scaled-down raster keeps the run short while preserving every timing relation
    localparam int H_ACT   = 16;
    localparam int H_FP    = 2;
    localparam int H_SYNC  = 3;
    localparam int H_TOT   = 24;
    localparam int V_ACT   = 8;
    localparam int V_FP    = 2;
    localparam int V_SYNC  = 2;
    localparam int V_TOT   = 14;
    localparam int VS_LINE = V_ACT + V_FP;
    localparam int N_FRAMES = 18;
    localparam logic [11:0] c_PROBE_COLOUR = 12'hF0A;

    typedef struct {
        int stretchLine;
        int longLine;
        int rstLine;
        int px;
        int py;
        int expLocked;
        int expErr;
        int expLines;
        int expLen;
        int expStb;
    } frame_t;

    logic        clk = 1'b0;
    logic        iRST_n = 1'b0;
    logic        iHS = 1'b1;
    logic        iVS = 1'b1;
    logic        iBLANK_n = 1'b0;
    logic [3:0]  iVGA_R = '0;
    logic [3:0]  iVGA_G = '0;
    logic [3:0]  iVGA_B = '0;
    logic [10:0] iPROBE_X = '0;
    logic [9:0]  iPROBE_Y = '0;
    logic [10:0] oXPOS;
    logic [9:0]  oYPOS;
    logic        oPIX_VALID;
    logic        oLOCKED;
    logic [10:0] oLINE_LEN;
    logic [9:0]  oFRAME_LINES;
    logic [11:0] oPROBE_RGB;
    logic        oPROBE_STB;
    logic        oERR;

    vga_sync_receiver #(
        .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .H_TOTAL(H_TOT), .LOCK_FRAMES(2)
    ) dut (
        .iVGA_CLK(clk), .iRST_n(iRST_n), .iHS(iHS), .iVS(iVS), .iBLANK_n(iBLANK_n),
        .iVGA_R(iVGA_R), .iVGA_G(iVGA_G), .iVGA_B(iVGA_B),
        .iPROBE_X(iPROBE_X), .iPROBE_Y(iPROBE_Y),
        .oXPOS(oXPOS), .oYPOS(oYPOS), .oPIX_VALID(oPIX_VALID), .oLOCKED(oLOCKED),
        .oLINE_LEN(oLINE_LEN), .oFRAME_LINES(oFRAME_LINES),
        .oPROBE_RGB(oPROBE_RGB), .oPROBE_STB(oPROBE_STB), .oERR(oERR)
    );

    always #5 clk = ~clk;

    int          nVec = 0;
    int          nErr = 0;
    int          modelY = 0;
    int          stbCount = 0;
    int          curPx = 0;
    int          curPy = 0;
    logic [20:0] pixQ[$];
    frame_t      frames[N_FRAMES];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every active pixel driven must reappear two cycles later with its coordinates
    always @(negedge clk) begin
        if (iRST_n) begin
            if (oPIX_VALID) begin
                if (pixQ.size() == 0) begin
                    chk("pix_unexpected", 64'd1, 64'd0);
                end else begin
                    logic [20:0] e;
                    e = pixQ.pop_front();
                    chk("xpos", 64'(oXPOS), 64'(e[20:10]));
                    chk("ypos", 64'(oYPOS), 64'(e[9:0]));
                end
            end
            if (oPROBE_STB) begin
                stbCount++;
                chk("probe_x", 64'(oXPOS), 64'(curPx));
                chk("probe_y", 64'(oYPOS), 64'(curPy));
                chk("probe_rgb", 64'(oPROBE_RGB), 64'(c_PROBE_COLOUR));
            end
        end
    end

    task automatic run_frame(input int idx, input frame_t f, input int prevLocked);
        int lockedBefore;
        lockedBefore = prevLocked;
        stbCount = 0;
        curPx    = f.px;
        curPy    = f.py;
        iPROBE_X = 11'(f.px);
        iPROBE_Y = 10'(f.py);
        for (int v = 0; v < V_TOT; v++) begin
            int hlen;
            int act;
            hlen = H_TOT + ((v == f.longLine) ? 1 : 0);
            act  = H_ACT + ((v == f.stretchLine) ? 1 : 0);
            for (int h = 0; h < hlen; h++) begin
                logic        active;
                logic [11:0] colour;
                @(posedge clk);
                #1;
                active   = (v < V_ACT) && (h < act);
                colour   = (active && h == f.px && v == f.py) ? c_PROBE_COLOUR : 12'h000;
                iBLANK_n = active;
                iHS      = !(h >= H_ACT + H_FP && h < H_ACT + H_FP + H_SYNC);
                iVS      = !(v >= VS_LINE && v < VS_LINE + V_SYNC);
                {iVGA_R, iVGA_G, iVGA_B} = colour;
                if (active)
                    pixQ.push_back({11'(h), 10'(modelY)});
                if (v < V_ACT && h == act)
                    modelY++;
                if (v == VS_LINE && h == 0)
                    modelY = 0;
                if (v == f.rstLine && h == H_ACT + 4) begin
                    iRST_n = 1'b0;
                    #1;
                    chk("reset_outputs", 64'({oXPOS, oYPOS, oPIX_VALID, oLOCKED, oLINE_LEN,
                                              oFRAME_LINES, oPROBE_RGB, oPROBE_STB, oERR}), 64'd0);
                    pixQ.delete();
                    modelY       = 0;
                    lockedBefore = 0;
                end
                if (v == f.rstLine && h == H_ACT + 6)
                    iRST_n = 1'b1;
                if (v == VS_LINE && h == 1) begin
                    @(negedge clk);
                    chk($sformatf("f%0d_lock_vs+1", idx), 64'(oLOCKED), 64'(lockedBefore));
                end
                if (v == VS_LINE && h == 2) begin
                    @(negedge clk);
                    chk($sformatf("f%0d_lock_vs+2", idx), 64'(oLOCKED), 64'(f.expLocked));
                end
            end
        end
        @(negedge clk);
        chk($sformatf("f%0d_locked", idx), 64'(oLOCKED), 64'(f.expLocked));
        chk($sformatf("f%0d_err", idx), 64'(oERR), 64'(f.expErr));
        chk($sformatf("f%0d_frame_lines", idx), 64'(oFRAME_LINES), 64'(f.expLines));
        chk($sformatf("f%0d_line_len", idx), 64'(oLINE_LEN), 64'(f.expLen));
        chk($sformatf("f%0d_probe_stb_count", idx), 64'(stbCount), 64'(f.expStb));
    endtask

    initial begin
        //           stretch long rst  px  py  lock err lines len stb
        frames[0]  = '{-1, -1, -1, 10, 5, 0, 0, 8, 16, 0};
        frames[1]  = '{-1, -1, -1, 10, 5, 0, 0, 8, 16, 0};
        frames[2]  = '{-1, -1, -1, 10, 5, 1, 0, 8, 16, 0};
        frames[3]  = '{-1, -1, -1, 10, 5, 1, 0, 8, 16, 1};
        frames[4]  = '{ 3, -1, -1, 10, 5, 0, 1, 8, 16, 1};
        frames[5]  = '{-1, -1, -1, 10, 5, 0, 1, 8, 16, 0};
        frames[6]  = '{-1, -1, -1, 10, 5, 1, 1, 8, 16, 0};
        frames[7]  = '{-1, -1, -1, 20, 2, 1, 1, 8, 16, 0};
        frames[8]  = '{-1, -1, -1,  3, 7, 1, 1, 8, 16, 1};
        frames[9]  = '{ 7, -1, -1,  3, 7, 0, 1, 8, 17, 1};
        frames[10] = '{-1, -1,  4, 10, 5, 0, 0, 3, 16, 0};
        frames[11] = '{-1, -1, -1, 10, 5, 0, 0, 8, 16, 0};
        frames[12] = '{-1, -1, -1, 10, 5, 1, 0, 8, 16, 0};
        frames[13] = '{ 3, -1, -1, 10, 5, 0, 1, 8, 16, 1};
        frames[14] = '{-1,  3, -1, 10, 5, 0, 1, 8, 16, 0};
        frames[15] = '{-1, -1, -1, 10, 5, 0, 1, 8, 16, 0};
        frames[16] = '{-1, -1, -1, 10, 5, 1, 1, 8, 16, 0};
        frames[17] = '{-1, -1, -1, 10, 5, 1, 1, 8, 16, 1};

        iRST_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_init", 64'({oXPOS, oYPOS, oPIX_VALID, oLOCKED, oLINE_LEN,
                                       oFRAME_LINES, oPROBE_RGB, oPROBE_STB, oERR}), 64'd0);
        iRST_n = 1'b1;
        repeat (4) @(posedge clk);

        for (int i = 0; i < N_FRAMES; i++)
            run_frame(i, frames[i], (i == 0) ? 0 : frames[i - 1].expLocked);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pix_queue_drained", 64'(pixQ.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
